csa_resolver: RTL and testbench

Sequential carry-propagate stage that turns the redundant sum/carry vector pair from the Wallace multiplier's final carry-save level into a binary product. It adds the pair in CHUNK-bit slices, one slice per cycle, with a registered inter-slice carry. It sits between the multiplier tree and the multiply unit's common-data-bus result register, carrying the reservation-station tag alongside the data. Inputs use a valid/ready handshake; outputs use a valid/ready handshake.

---
 rtl/csa_resolver.sv | 128 ++++++++++++
 tb/tb_csa_resolver.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/csa_resolver.sv
// rtl/csa_resolver.sv - sliced carry-propagate adder resolving a carry-save pair (optional CSA_RESOLVER_EARLY_EN)
module csa_resolver #(
    parameter int W     = 64,
    parameter int CHUNK = 16,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     sum_vec,
    input  logic [W-1:0]     carry_vec,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int NCHUNK = W / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int SH_W   = $clog2(W) + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       sum_q, sum_d;
    logic [W-1:0]       cv_q, cv_d;
    logic [W-1:0]       result_q, result_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               cin_q, cin_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic [SH_W-1:0]    base;
    logic [CHUNK:0]     slice_sum;
    logic               last_slice;
    logic               early_done;

    assign base       = SH_W'(idx_q) * SH_W'(CHUNK);
    assign slice_sum  = {1'b0, sum_q[base +: CHUNK]} + {1'b0, cv_q[base +: CHUNK]}
                      + {{CHUNK{1'b0}}, cin_q};
    assign last_slice = (idx_q == IDX_W'(NCHUNK - 1));

`ifdef CSA_RESOLVER_EARLY_EN
    logic [SH_W-1:0] next_base;
    logic            upper_zero;

    // Nothing left to add above this slice: the remaining result slices stay 0.
    assign next_base  = base + SH_W'(CHUNK);
    assign upper_zero = (((sum_q | cv_q) >> next_base) == '0);
    assign early_done = !slice_sum[CHUNK] && upper_zero;
`else
    assign early_done = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        cv_d     = cv_q;
        result_d = result_q;
        tag_d    = tag_q;
        cin_d    = cin_q;
        idx_d    = idx_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        sum_d    = sum_vec;
                        cv_d     = carry_vec;
                        tag_d    = in_tag;
                        result_d = '0;
                        cin_d    = 1'b0;
                        idx_d    = '0;
                        state_d  = S_ADD;
                    end
                end
                S_ADD: begin
                    // Carry out of the top slice falls off: result is modulo 2^W.
                    result_d[base +: CHUNK] = slice_sum[CHUNK-1:0];
                    cin_d                   = slice_sum[CHUNK];
                    idx_d                   = idx_q + IDX_W'(1);
                    if (last_slice || early_done) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sum_q    <= '0;
            cv_q     <= '0;
            result_q <= '0;
            tag_q    <= '0;
            cin_q    <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            cv_q     <= cv_d;
            result_q <= result_d;
            tag_q    <= tag_d;
            cin_q    <= cin_d;
            idx_q    <= idx_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign out_tag   = tag_q;

endmodule

// File: tb/tb_csa_resolver.sv
// tb/tb_csa_resolver.sv - directed-vector bench for csa_resolver
module tb_csa_resolver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] sum_vec;
    logic [63:0] carry_vec;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic [3:0]  out_tag;

    int n_vec  = 0;
    int n_miss = 0;

`ifdef CSA_RESOLVER_EARLY_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    always #5 clk = ~clk;

    csa_resolver dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_vec   (sum_vec),
        .carry_vec (carry_vec),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_tag   (out_tag)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [63:0] s, input logic [63:0] c, input logic [3:0] t);
        check("accept_ready", in_ready, 1'b1);
        sum_vec   = s;
        carry_vec = c;
        in_tag    = t;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("post_hs_valid", out_valid, 1'b0);
        check("post_hs_ready", in_ready, 1'b1);
    endtask

    task automatic no_valid(input string tag, input int n);
        logic seen;
        seen = 1'b0;
        repeat (n) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        check(tag, seen, 1'b0);
    endtask

    initial begin
        int lat;
        int hits;
        int first_hit;
        int period;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sum_vec = '0; carry_vec = '0; in_tag = '0;
        #12;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", result, 64'h0);
        check("rst_tag", out_tag, 4'h0);
        rst_n = 1'b1;
        step();

        // full carry ripple, then a 10-cycle output stall
        start(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 4'h9);
        wait_valid(lat);
        check("ripple_lat", lat, 4);
        check("ripple_result", result, 64'h0);
        check("ripple_tag", out_tag, 4'h9);
        check("ripple_in_ready", in_ready, 1'b0);
        repeat (10) step();
        check("stall_valid", out_valid, 1'b1);
        check("stall_result", result, 64'h0);
        check("stall_tag", out_tag, 4'h9);
        check("stall_in_ready", in_ready, 1'b0);
        release_out();

        // leaves nonzero upper slices so the next op shows they are cleared
        start(64'hAAAA_0000_0000_0000, 64'h0, 4'h3);
        wait_valid(lat);
        check("upper_lat", lat, 4);
        check("upper_result", result, 64'hAAAA_0000_0000_0000);
        release_out();

        start(64'h0000_0012_3456_0000, 64'h0000_0000_0001_0000, 4'h5);
        step();
        step();
        check("typ_partial", result, 64'h0000_0000_3457_0000);
        wait_valid(lat);
        check("typ_lat", lat + 2, EARLY ? 3 : 4);
        check("typ_result", result, 64'h0000_0012_3457_0000);
        check("typ_tag", out_tag, 4'h5);
        release_out();

        start(64'h5, 64'h3, 4'h1);
        wait_valid(lat);
        check("small_lat", lat, EARLY ? 1 : 4);
        check("small_result", result, 64'h8);
        release_out();

        // flush in second ADD cycle, with in_valid also asserted
        start(64'h1, 64'h2, 4'h2);
        step();
        flush    = 1'b1;
        in_valid = 1'b1;
        step();
        check("flush_in_ready", in_ready, 1'b1);
        check("flush_out_valid", out_valid, 1'b0);
        step();
        check("flush_idle_hold", in_ready, 1'b1);
        flush    = 1'b0;
        in_valid = 1'b0;
        no_valid("flush_no_valid", 8);

        // asynchronous reset mid-ADD (slice 0 already holds 3)
        start(64'h1, 64'h2, 4'h4);
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_result", result, 64'h0);
        check("midrst_tag", out_tag, 4'h0);
        rst_n = 1'b1;
        no_valid("midrst_no_valid", 8);

        // back-to-back throughput with both handshakes held high
        sum_vec   = 64'hFFFF_FFFF_FFFF_FFFF;
        carry_vec = 64'h1;
        in_tag    = 4'h7;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        hits = 0; first_hit = 0; period = 0;
        for (int i = 1; i <= 30 && hits < 2; i++) begin
            step();
            if (out_valid) begin
                if (hits == 0) first_hit = i;
                else period = i - first_hit;
                hits++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_period", period, 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
